// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: digit-slot encoding and 7-segment glyph constants (active low, {g,f,e,d,c,b,a})
package bcd_seg_pkg;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_e;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low 7-segment decoder; bcd_i nibble in, seg_o {g,f,e,d,c,b,a} out, non-BCD shows a dash
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_seg_display.sv
// bcd_seg_display: 4-digit common-anode scanner with frame-boundary BCD capture and periodic START pulse
// Ports: CLK clock, RST_N async active-low reset, BCDIN packed 4-digit BCD, START one-cycle convert request,
//        AN active-low anodes (AN[0]=ones), SEG active-low {g,f,e,d,c,b,a}, DP decimal point (always off).
// Build option: define BCD_SEG_LZB_EN to blank leading zeros in the upper three digit slots.
module bcd_seg_display
  import bcd_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int START_PERIOD = 5000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] BCDIN,
  output logic        START,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);
  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int ST_W = $clog2(START_PERIOD);
  logic [RC_W-1:0] rc_q;
  logic [ST_W-1:0] st_cnt_q;
  dig_e            state_q, state_d;
  logic [15:0]     shadow_q;
  logic [3:0]      an_q, an_d, nib;
  logic [6:0]      seg_q, seg_d, glyph;
  logic            start_q, wrap, st_wrap, off;
  logic            lz;
  assign wrap    = rc_q == RC_W'(REFRESH_DIV - 1);
  assign st_wrap = st_cnt_q == ST_W'(START_PERIOD - 1);
  assign state_d = wrap ? dig_e'(state_q + 2'd1) : state_q;
  assign nib     = state_q == DIG3 ? shadow_q[15:12] :
                   state_q == DIG2 ? shadow_q[11:8]  :
                   state_q == DIG1 ? shadow_q[7:4]   : shadow_q[3:0];
`ifdef BCD_SEG_LZB_EN
  // a digit is a leading zero when it and every higher digit are zero; ones is never blanked
  assign lz = (state_q == DIG3 && shadow_q[15:12] == 4'd0) ||
              (state_q == DIG2 && shadow_q[15:8] == 8'd0) ||
              (state_q == DIG1 && shadow_q[15:4] == 12'd0);
`else
  assign lz = 1'b0;
`endif
  assign off  = rc_q < RC_W'(BLANK_CYCLES) || lz;
  assign an_d  = off ? 4'hF : ~(4'b0001 << state_q);
  assign seg_d = off ? SEG_BLANK : glyph;
  bcd_to_seg7 u_dec (.bcd_i(nib), .seg_o(glyph));
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rc_q     <= '0;
      state_q  <= DIG0;
      shadow_q <= 16'h0000;
      an_q     <= 4'hF;
      seg_q    <= SEG_BLANK;
    end else begin
      rc_q    <= wrap ? '0 : rc_q + RC_W'(1);
      state_q <= state_d;
      // capture only on DIG3->DIG0 so a frame never mixes two values
      if (wrap && state_q == DIG3) shadow_q <= BCDIN;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_cnt_q <= '0;
      start_q  <= 1'b0;
    end else begin
      st_cnt_q <= st_wrap ? '0 : st_cnt_q + ST_W'(1);
      start_q  <= st_wrap;
    end
  end
  assign START = start_q;
  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = 1'b1;
endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display: scoreboard bench against a frame/slot arithmetic model of the display
module tb_bcd_seg_display;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int SP = 64;
`ifdef BCD_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] GL [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       st;
  } exp_t;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] BCDIN = 16'h1234;
  logic        START, DP;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          n = 0;
  logic [15:0] sh = 16'h0000;

  bcd_seg_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .START_PERIOD(SP)) dut (
    .CLK(CLK), .RST_N(RST_N), .BCDIN(BCDIN), .START(START), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  // expected outputs after clock k (k>=1) since reset release; they describe time step t=k-1
  function automatic exp_t model(int t, logic [15:0] s, int k);
    int d = (t / RD) % 4;
    int nib = int'((s >> (4 * d)) & 16'hF);
    bit off = (t % RD) < BC || (LZB && d > 0 && (s >> (4 * d)) == 16'h0);
    model.an  = off ? 4'hF : ~(4'b0001 << d);
    model.seg = off ? 7'h7F : (nib > 9 ? 7'h3F : GL[nib]);
    model.st  = (k % SP) == 0;
  endfunction

  function automatic logic [15:0] rnd_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: push one expectation per clock, shadow reloads at each 4-slot frame boundary
  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      n = 0;
      sh = 16'h0000;
      q.delete();
    end else begin
      n++;
      q.push_back(model(n - 1, sh, n));
      if (n % (4 * RD) == 0) sh = BCDIN;
    end
  end

  // monitor: reset values while RST_N is low, otherwise pop and compare each cycle
  initial forever begin
    @(negedge CLK or negedge RST_N);
    if (!RST_N) begin
      #1;
      chk("reset_an", 32'(AN), 32'hF);
      chk("reset_seg", 32'(SEG), 32'h7F);
      chk("reset_start", 32'(START), 32'h0);
      chk("reset_dp", 32'(DP), 32'h1);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(AN), 32'(e.an));
      chk("seg", 32'(SEG), 32'(e.seg));
      chk("start", 32'(START), 32'(e.st));
      chk("dp", 32'(DP), 32'h1);
    end
  end

  initial begin
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (44) @(posedge CLK);
    #1 BCDIN = 16'h5678;
    repeat (40) @(posedge CLK);
    #1 BCDIN = 16'h00A0;
    repeat (64) @(posedge CLK);
    #1 BCDIN = 16'h0007;
    repeat (64) @(posedge CLK);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 40)) @(posedge CLK);
      case ($urandom_range(0, 2))
        0: #1 BCDIN = 16'($urandom);
        1: #1 BCDIN = rnd_bcd();
        default: #1 BCDIN = rnd_bcd() >> (4 * $urandom_range(1, 3));
      endcase
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge CLK);
      #1;
      if (n % (4 * RD) == 20) break;
    end
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    for (int i = 0; i < 9; i++) begin
      repeat (30) @(posedge CLK);
      #1 BCDIN = rnd_bcd();
    end
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Downstream consumer of the packed 4-digit BCD converter output (thousands/hundreds/tens/ones nibbles).
- Multiplexes the captured value onto a 4-digit common-anode 7-segment display with active-low anodes and segments.
- Also generates the periodic single-cycle START request that triggers the upstream conversion.
- Captures the BCD input only at frame boundaries, so a displayed frame is never torn.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting guard).
- START_PERIOD, 5000000, cycles between START pulses; must be >= 64 so the upstream conversion (about 40 cycles) completes.

Ports:
- CLK  in  1  system clock, 100 MHz
- RST_N  in  1  asynchronous active-low reset
- BCDIN  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
- START  out  1  one-cycle pulse to the upstream converter
- AN  out  4  anode enables, active low; AN[0] is the ones digit
- SEG  out  7  cathodes, active low, bit order {g,f,e,d,c,b,a}
- DP  out  1  decimal point, active low; tied to 1 (off)

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active low; asserting it, including mid-scan, clears all state immediately.
- Reset values: AN=4'hF, SEG=7'h7F, DP=1, START=0, shadow register=16'h0000, refresh count rc=0, start counter=0, FSM=DIG0.
- Refresh counter: rc counts 0..REFRESH_DIV-1 and wraps to 0. On wrap the FSM advances DIG0->DIG1->DIG2->DIG3->DIG0.
- Frame capture: on the DIG3->DIG0 transition, the shadow register loads BCDIN. BCDIN changes mid-frame are ignored until the next boundary.
- Outputs: AN and SEG are registered and reflect the current FSM state and rc with 1-cycle latency.
  - Blank window (rc < BLANK_CYCLES): AN=4'hF, SEG=7'h7F.
  - Otherwise: AN has 0 only at the current digit's bit, and SEG = decode(shadow nibble for that digit).
- Decode:
  - Nibbles 0-9 map to the standard glyphs: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - Nibbles A-F show a dash: 7'b0111111 (segment g only).
- START generator:
  - Free-running counter 0..START_PERIOD-1.
  - START=1 for exactly one cycle when the counter equals START_PERIOD-1; first pulse occurs START_PERIOD cycles after RST_N deasserts.
  - Independent of the scan FSM; the two counters reaching terminal count in the same cycle need no arbitration.

Optional Feature:
- Macro BCD_SEG_LZB_EN enables leading-zero blanking.
- Defined: digit slots 3, 2 and 1 keep AN=1 for the whole slot when that digit and every higher digit in the shadow value are 0. The ones digit is always shown. Evaluation uses the shadow value only.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package bcd_seg_pkg:
  - digit-state encoding (DIG0..DIG3, 2-bit);
  - SEG glyph constants for 0-9;
  - SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
- Sub-module bcd_to_seg7: combinational 4-bit-to-7-segment decoder, instantiated once on the muxed nibble.
- Everything else stays in the top module.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, START_PERIOD=64):
- Reset: hold RST_N low, then assert it again mid-slot in DIG2 -> AN=4'hF, SEG=7'h7F, START=0 in the same cycle (asynchronous); scan restarts at DIG0, rc=0.
- Display: BCDIN=16'h1234 through one frame boundary, then observe the DIG0 slot -> cycles 0-1 show AN=4'hF; cycles 2-7 show AN=4'b1110, SEG=7'b0011001 (glyph 4). The DIG3 slot shows AN=4'b0111, SEG=7'b1111001 (glyph 1).
- Tear-free capture: change BCDIN from 16'h1234 to 16'h5678 during DIG1 -> DIG2 and DIG3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
- START: count cycles after reset release -> single-cycle START at cycles 64, 128 and 192; START is low in every other cycle.
- Invalid input: BCDIN=16'h00A0 -> tens slot shows SEG=7'b0111111; the other slots show glyph 0 (macro undefined).
- Macro: BCDIN=16'h0007 with BCD_SEG_LZB_EN defined -> AN stays 4'hF during slots 1-3, and slot 0 shows 7'b1111000. With the macro undefined, slots 1-3 show 7'b1000000.
